// File: rtl/osiris_uart_rx_pkg.sv
// osiris_uart_pkg: shared UART types and constants.
// Optional feature macro: OSIRIS_UART_RX_PARITY_EN (adds the PARITY state).
package osiris_uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;   // 50 MHz / 115200 baud

    // Receiver FSM states; shared with the transmitter to come.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef OSIRIS_UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/osiris_uart_rx_if.sv
// osiris_uart_rx_if: byte hand-over from the UART receiver to its consumer.
// master = receiver (drives data/valid), slave = consumer (drives ready).
interface osiris_uart_rx_if;
    import osiris_uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/osiris_uart_rx_sync_2ff.sv
// osiris_sync_2ff: generic two-flop synchronizer with a configurable reset value.
module osiris_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/osiris_uart_rx.sv
// osiris_uart_rx: 8N1 UART receiver with a single-entry valid/ready holding
// register and one-cycle framing / parity / overrun pulses.
// Optional feature macro: OSIRIS_UART_RX_PARITY_EN (even parity bit after data).
module osiris_uart_rx
    import osiris_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    osiris_uart_rx_if.master    rx_if,
    output logic                rx_busy,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      w_rx;
    uart_rx_state_t            r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_idx;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_rx_prev;
    logic                      r_frame_err;
    logic                      r_overrun;
    logic                      w_hs;
`ifdef OSIRIS_UART_RX_PARITY_EN
    logic                      r_par;
    logic                      r_par_bad;
    logic                      r_parity_err;
`endif

    osiris_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (uart_rx),
        .o_q   (w_rx)
    );

    assign w_hs = r_valid && rx_if.rx_ready;

    // Frame FSM, bit timing, shift register, holding register and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_rx_prev   <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef OSIRIS_UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef OSIRIS_UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            r_rx_prev   <= w_rx;
            // A plain handshake empties the holding register; a completion
            // in the same cycle overrides this below.
            if (w_hs)
                r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_cnt   <= CNT_HALF;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == '0) begin
                        if (w_rx) begin
                            r_state <= ST_IDLE;            // false start
                        end else begin
                            r_cnt   <= CNT_FULL;
                            r_idx   <= '0;
`ifdef OSIRIS_UART_RX_PARITY_EN
                            r_par   <= 1'b0;
`endif
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == '0) begin
                        r_shreg <= {w_rx, r_shreg[UART_DATA_BITS-1:1]};  // LSB first
`ifdef OSIRIS_UART_RX_PARITY_EN
                        r_par   <= r_par ^ w_rx;
`endif
                        r_cnt   <= CNT_FULL;
                        if (r_idx == LAST_BIT) begin
`ifdef OSIRIS_UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef OSIRIS_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == '0) begin
                        r_par_bad <= r_par ^ w_rx;         // even parity
                        r_cnt     <= CNT_FULL;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == '0) begin
                        if (!w_rx) begin
                            // Low stop bit wins over any parity error.
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end else begin
                            r_state <= ST_IDLE;
`ifdef OSIRIS_UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else
`endif
                            if (!r_valid || w_hs) begin
                                r_data  <= r_shreg;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;         // keep the old byte
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data  = r_data;
    assign rx_if.rx_valid = r_valid;
    assign rx_busy        = (r_state != ST_IDLE);
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;
`ifdef OSIRIS_UART_RX_PARITY_EN
    assign parity_err     = r_parity_err;
`else
    assign parity_err     = 1'b0;
`endif

endmodule
